// File: rtl/accum_sequencer.sv
// Accumulator stage: adds or subtracts a stream of operands from a running sum over valid/ready.
// Optional ACCUM_SATURATE_EN: on signed overflow the accumulator clamps instead of wrapping.
module accum_sequencer #(
  parameter int unsigned n  = 32,
  parameter int unsigned CW = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic [CW-1:0] Count,
  input  logic          Sub,
  input  logic          DinValid,
  input  logic [n-1:0]  Din,
  output logic          DinReady,
  output logic [n-1:0]  Result,
  output logic          Carry,
  output logic          Overflow,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e        state_q;
  logic [n-1:0]  acc_q;
  logic          carry_q;
  logic          ovf_q;
  logic          busy_q;
  logic          done_q;
  logic          sub_q;
  logic [CW-1:0] remaining_q;

  logic [n-1:0]  y;
  logic [n-1:0]  s;
  logic [n-1:0]  acc_d;
  logic          cout;
  logic          ov;
  logic          xfer;

  assign DinReady = (state_q == StAccum);
  assign xfer     = DinValid & DinReady;

  // Subtraction is Acc + ~Din + 1, so the carry-in doubles as the subtract flag.
  always_comb begin
    y    = sub_q ? ~Din : Din;
    s    = acc_q + y + {{(n-1){1'b0}}, sub_q};
    cout = (acc_q[n-1] & y[n-1]) | (acc_q[n-1] & ~s[n-1]) | (y[n-1] & ~s[n-1]);
    ov   = (acc_q[n-1] & y[n-1] & ~s[n-1]) | (~acc_q[n-1] & ~y[n-1] & s[n-1]);
  end

`ifdef ACCUM_SATURATE_EN
  // Overflow direction follows the sign of the old accumulator.
  always_comb begin
    acc_d = s;
    if (ov) begin
      acc_d = acc_q[n-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
    end
  end
`else
  always_comb begin
    acc_d = s;
  end
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sub_q       <= 1'b0;
      remaining_q <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (Start) begin
            acc_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            sub_q       <= Sub;
            remaining_q <= Count;
            if (Count != '0) begin
              state_q <= StAccum;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StAccum: begin
          if (xfer) begin
            acc_q       <= acc_d;
            carry_q     <= cout;
            ovf_q       <= ovf_q | ov;
            remaining_q <= remaining_q - CW'(1);
            if (remaining_q == CW'(1)) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Result   = acc_q;
  assign Carry    = carry_q;
  assign Overflow = ovf_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_accum_sequencer.sv
// Self-checking bench for accum_sequencer: arithmetic reference model plus directed and random runs.
module tb_accum_sequencer;

  localparam int unsigned N  = 32;
  localparam int unsigned CW = 8;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic [CW-1:0] Count;
  logic          Sub;
  logic          DinValid;
  logic [N-1:0]  Din;
  logic          DinReady;
  logic [N-1:0]  Result;
  logic          Carry;
  logic          Overflow;
  logic          Busy;
  logic          Done;

  accum_sequencer #(.n(N), .CW(CW)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Count    (Count),
    .Sub      (Sub),
    .DinValid (DinValid),
    .Din      (Din),
    .DinReady (DinReady),
    .Result   (Result),
    .Carry    (Carry),
    .Overflow (Overflow),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  bit checking = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run phase 0 idle, 1 accumulating, 2 done; arithmetic done in 64-bit signed.
  int          m_phase;
  logic [N-1:0] m_acc;
  bit          m_carry, m_ovf, m_sub;
  int          m_rem;

  always @(posedge Clock) begin
    if (Reset) begin
      m_phase = 0; m_acc = '0; m_carry = 0; m_ovf = 0; m_sub = 0; m_rem = 0;
    end else if (m_phase != 1 && Start) begin
      m_acc = '0; m_carry = 0; m_ovf = 0; m_sub = Sub; m_rem = int'(Count);
      m_phase = (Count != 0) ? 1 : 2;
    end else if (m_phase == 1 && DinValid) begin
      longint sa, sd, sr;
      bit ov;
      sa = longint'($signed(m_acc));
      sd = longint'($signed(Din));
      if (m_sub) begin
        sr = sa - sd;
        m_carry = (m_acc >= Din);
      end else begin
        sr = sa + sd;
        m_carry = (longint'(m_acc) + longint'(Din)) >= 64'sh1_0000_0000;
      end
      ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      m_ovf = m_ovf | ov;
`ifdef ACCUM_SATURATE_EN
      if (ov) m_acc = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      else    m_acc = sr[N-1:0];
`else
      m_acc = sr[N-1:0];
`endif
      m_rem--;
      if (m_rem == 0) m_phase = 2;
    end
  end

  always @(negedge Clock) begin
    if (checking) begin
      check("result",   Result,   m_acc);
      check("carry",    Carry,    m_carry);
      check("overflow", Overflow, m_ovf);
      check("busy",     Busy,     m_phase == 1);
      check("done",     Done,     m_phase == 2);
      check("dinready", DinReady, m_phase == 1);
    end
  end

  task automatic cyc();
    @(negedge Clock);
  endtask

  task automatic start_run(input int cnt, input bit sb);
    Start = 1'b1; Count = CW'(cnt); Sub = sb;
    cyc();
    Start = 1'b0;
  endtask

  task automatic feed(input logic [N-1:0] d);
    DinValid = 1'b1; Din = d;
    cyc();
    DinValid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Count = '0; Sub = 1'b0; DinValid = 1'b0; Din = '0;
    cyc(); cyc();
    Reset = 1'b0;
    checking = 1;
    check("reset_result", Result, 0);
    check("reset_done", Done, 0);

    // 5 + 7 + 10
    start_run(3, 0);
    feed(5); feed(7);
    check("t1_not_done_yet", Done, 0);
    feed(10);
    check("t1_result", Result, 22);
    check("t1_done", Done, 1);
    check("t1_busy", Busy, 0);
    check("t1_carry", Carry, 0);

    // 0 - 3 - 5, back-to-back from DONE
    start_run(2, 1);
    feed(3);
    check("t2_mid_result", Result, 32'hFFFF_FFFD);
    check("t2_mid_carry", Carry, 0);
    feed(5);
    check("t2_result", Result, 32'hFFFF_FFF8);
    check("t2_carry", Carry, 1);
    check("t2_ovf", Overflow, 0);

    start_run(2, 0);
    feed(32'h7FFF_FFFF); feed(32'h1);
    check("t3_ovf", Overflow, 1);
`ifdef ACCUM_SATURATE_EN
    check("t3_result", Result, 32'h7FFF_FFFF);
`else
    check("t3_result", Result, 32'h8000_0000);
`endif
    start_run(3, 0);
    feed(32'h7FFF_FFFF); feed(32'h1); feed(32'hFFFF_FFFF);
    check("t3b_ovf_sticky", Overflow, 1);
`ifdef ACCUM_SATURATE_EN
    check("t3b_result", Result, 32'h7FFF_FFFE);
`else
    check("t3b_result", Result, 32'h7FFF_FFFF);
`endif

    // Gapped transfers with a stray Start mid-run
    start_run(4, 0);
    for (int i = 1; i <= 4; i++) begin
      feed(i);
      cyc();
      if (i == 2) begin Start = 1'b1; Count = 8'd0; end
      cyc();
      Start = 1'b0;
    end
    check("t4_result", Result, 10);
    check("t4_done", Done, 1);
    start_run(0, 0);
    check("t4_zero_done", Done, 1);
    check("t4_zero_result", Result, 0);

    // Reset mid-run
    start_run(3, 0);
    feed(9);
    Reset = 1'b1; cyc(); Reset = 1'b0;
    check("t5_result", Result, 0);
    check("t5_ready", DinReady, 0);
    check("t5_busy", Busy, 0);
    start_run(3, 0);
    feed(1); feed(2); feed(3);
    check("t5_rerun", Result, 6);

    // Random traffic; the model checks every cycle
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      Reset    = (r == 0);
      Start    = ($urandom_range(0, 7) == 0);
      Count    = ($urandom_range(0, 40) == 0) ? 8'hFF : CW'($urandom_range(0, 6));
      Sub      = $urandom_range(0, 1) == 1;
      DinValid = $urandom_range(0, 9) < 6;
      case ($urandom_range(0, 3))
        0: Din = 32'h7FFF_FFFF;
        1: Din = 32'h8000_0000;
        2: Din = N'($urandom_range(0, 15));
        default: Din = $urandom;
      endcase
      cyc();
    end
    Reset = 1'b0; Start = 1'b0; DinValid = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
- Sequential accumulator stage that sits directly downstream of the n-bit ripple/behavioural adder and feeds it.
- Accepts a stream of n-bit operands over a valid/ready handshake.
- Adds each operand to, or subtracts it from, a running accumulator, using the adder equations for carry and two's-complement overflow.
- After a programmed number of operands it reports Done with the result and a sticky overflow flag.

Parameters:
- n, 32, operand/accumulator width in bits
- CW, 8, width of operand-count field

Ports:
- Clock  input  1  system clock, all state changes on rising edge
- Reset  input  1  synchronous active-high reset
- Start  input  1  one-cycle pulse: begin a new accumulation run (sampled in IDLE and DONE only)
- Count  input  CW  number of operands in the run, sampled with Start
- Sub  input  1  0 = Acc+Din, 1 = Acc-Din; sampled with Start, fixed for the run
- DinValid  input  1  operand valid
- Din  input  n  operand
- DinReady  output  1  block accepts operand this cycle
- Result  output  n  accumulator value
- Carry  output  1  carryout of most recent operation (for Sub: 1 = no borrow)
- Overflow  output  1  sticky two's-complement overflow for current run
- Busy  output  1  run in progress
- Done  output  1  run complete, Result final

Behaviour:
- One clock; reset is synchronous and active-high. Clock/reset ports are named Clock and Reset.
- Reset, including mid-run:
  - state IDLE; Result, Carry, Overflow, Busy, Done = 0; internal remaining counter = 0.
  - A partial run is discarded.
- States: IDLE, ACCUM, DONE (2-bit encoded register).
- IDLE: DinReady=0, Busy=0, Done=0.
  - Start=1, Count!=0: next cycle Acc=0, Carry=0, Overflow=0, Remaining=Count, Sub latched, state ACCUM, Busy=1.
  - Start=1, Count=0: next cycle Acc=0, flags cleared, state DONE, Done=1.
- ACCUM: DinReady=1 combinationally (state==ACCUM); Busy=1.
  - Transfer = DinValid & DinReady. No transfer means no state change.
  - On transfer: Y = Sub ? ~Din : Din, cin = Sub, S = Acc + Y + cin (n-bit, modulo 2^n).
  - Carry <= (Acc[n-1]&Y[n-1]) | (Acc[n-1]&~S[n-1]) | (Y[n-1]&~S[n-1]).
  - ov = (Acc[n-1]&Y[n-1]&~S[n-1]) | (~Acc[n-1]&~Y[n-1]&S[n-1]); Overflow <= Overflow | ov.
  - Acc <= S; Remaining <= Remaining-1.
  - Transfer with Remaining==1: next state DONE, Busy=0, Done=1 in the cycle after the final transfer.
  - Start is ignored in ACCUM.
- DONE: Done=1, DinReady=0, Result/Carry/Overflow held.
  - Start=1 behaves exactly as Start in IDLE (back-to-back runs allowed, no idle cycle).
  - Stays in DONE indefinitely otherwise.
- Result = Acc at all times, so it is updated one cycle after each transfer. Latency from final transfer to Done = 1 cycle.
- Remaining is CW bits; Count = 2^CW-1 is legal. Remaining never wraps because state leaves ACCUM at 1.
- Simultaneous Start and Reset: Reset wins.

Optional Feature:
- Macro ACCUM_SATURATE_EN.
- Defined: on a transfer with ov=1, Acc clamps instead of wrapping.
  - Acc <= {1'b0,{n-1{1'b1}}} if Acc[n-1]==0 (positive overflow).
  - Acc <= {1'b1,{n-1{1'b0}}} if Acc[n-1]==1 (negative overflow).
  - Carry and Overflow are computed from the unclamped S as normal.
- Undefined: Acc <= S always (modulo wrap).
- Handshake and timing are identical in both builds.

Test Plan:
- Start, Count=3, Sub=0, Din 5,7,10 with DinValid held -> Result=22, Carry=0, Overflow=0; Done=1 exactly one cycle after third transfer; Busy=0.
- Start, Count=2, Sub=1, Din 3 then 5 -> after first transfer Result=0xFFFFFFFD, Carry=0; final Result=0xFFFFFFF8, Carry=1, Overflow=0.
- Start, Count=2, Sub=0, Din 0x7FFFFFFF then 1 -> Overflow=1.
  - Without ACCUM_SATURATE_EN: Result=0x80000000.
  - With ACCUM_SATURATE_EN: Result=0x7FFFFFFF.
  - Repeat with Count=3 and third Din 0xFFFFFFFF: Overflow stays 1 (sticky).
- Count=4, DinValid toggled with 2-cycle gaps and a Start pulse mid-run -> Result changes only on transfers; Start has no effect; sum correct after 4 transfers. Then Start, Count=0 in DONE -> Done=1 next cycle, Result=0, Overflow=0.
- Reset asserted one cycle after first transfer of a Count=3 run -> next cycle all outputs 0, DinReady=0, state IDLE; a subsequent full run gives the correct result.
